// File: rtl/mole_hit_ctrl.sv
// mole_hit_ctrl: debounced whack-a-mole button, lit/dark timing, hit scoring and score write-back into free regfile slots
module mole_hit_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ON_CYCLES = 10000000,
  parameter int OFF_CYCLES = 50000000,
  parameter logic [4:0] SCORE_REG = 5'd30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_n,
  input  logic        cpu_rwe,
  output logic        mole_led,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [31:0] score,
  output logic        wr_en,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic {LIT, DARK} state_t;
  state_t state;
  logic sync1, btn_s, btn_db, btn_db_d, dirty, press, hit;
  logic [DW-1:0] db_cnt;
  logic [31:0] timer;
  assign press = btn_db_d & ~btn_db;
  assign hit = (state == LIT) & press;
  assign wr_en = dirty & ~cpu_rwe;
  assign wr_reg = SCORE_REG;
  assign wr_data = score;
  // synchronise the raw button, accept a new level only after it holds long enough
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
      btn_db <= 1'b1;
      btn_db_d <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync1 <= btn_n;
      btn_s <= sync1;
      btn_db_d <= btn_db;
      if (btn_s == btn_db) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end
  // lit/dark timing, hit/miss pulses, score and pending-write flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= LIT;
      timer <= '0;
      mole_led <= 1'b1;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      score <= '0;
      dirty <= 1'b0;
    end else begin
      hit_pulse <= hit;
      miss_pulse <= 1'b0;
      if (state == LIT) begin
        if (press) begin
          state <= DARK;
          mole_led <= 1'b0;
          timer <= '0;
        end else if (timer == 32'(ON_CYCLES - 1)) begin
          state <= DARK;
          mole_led <= 1'b0;
          miss_pulse <= 1'b1;
          timer <= '0;
        end else timer <= timer + 32'd1;
      end else if (timer == 32'(OFF_CYCLES - 1)) begin
        state <= LIT;
        mole_led <= 1'b1;
        timer <= '0;
      end else timer <= timer + 32'd1;
      if (hit) score <= score + 32'd1;
      dirty <= hit | (dirty & ~wr_en);
    end
  end
endmodule

// File: tb/tb_mole_hit_ctrl.sv
// tb_mole_hit_ctrl: directed stimulus tables checked against a rule-level model plus hand-computed expectations
module tb_mole_hit_ctrl;
  localparam int DB = 4;
  localparam int ON = 20;
  localparam int OFF = 10;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_n = 1'b1;
  logic cpu_rwe = 1'b0;
  logic mole_led, hit_pulse, miss_pulse, wr_en;
  logic [31:0] score, wr_data;
  logic [4:0] wr_reg;
  int vectors = 0;
  int miscompares = 0;
  logic bp [1:64];
  logic rp [1:64];
  logic h [1:64];
  logic m [1:64];
  logic l [1:64];
  logic w [1:64];
  logic [31:0] s [1:64];
  logic [31:0] d [1:64];
  int nh, nm, nw, fh, fm, nl;
  int m_cyc, m_start;
  logic m_lit, m_hit, m_miss, m_dirty, m_level, m_fell, wrote;
  logic [31:0] m_score;
  logic [DB+1:0] m_raw;

  mole_hit_ctrl #(.DEBOUNCE_CYCLES(DB), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .SCORE_REG(5'd30)) dut (
    .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .cpu_rwe(cpu_rwe),
    .mole_led(mole_led), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm_s, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm_s, act, exp, $time);
    end
  endtask

  // Model: a level is accepted once the synchronised input (two samples late) has
  // differed from it for DB consecutive samples; a press is the cycle after a 1->0
  // acceptance. Phases are tracked by the edge they started on.
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_cyc = 0; m_start = 0; m_lit = 1'b1; m_score = 0; m_dirty = 1'b0;
      m_hit = 1'b0; m_miss = 1'b0; m_raw = '1; m_level = 1'b1; m_fell = 1'b0;
    end else begin
      m_cyc++;
      wrote = m_dirty & ~cpu_rwe;
      m_hit = m_lit & m_fell;
      m_miss = m_lit & ~m_fell & (m_cyc - m_start == ON);
      if (m_hit || m_miss || (!m_lit && m_cyc - m_start == OFF)) begin
        m_lit = ~m_lit;
        m_start = m_cyc;
      end
      if (m_hit) m_score = m_score + 1;
      m_dirty = m_hit | (m_dirty & ~wrote);
      m_raw = {m_raw[DB:0], btn_n};
      m_fell = 1'b0;
      if (m_raw[DB+1:2] == {DB{~m_level}}) begin
        m_fell = m_level;
        m_level = ~m_level;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      chk("led", mole_led, m_lit);
      chk("hit", hit_pulse, m_hit);
      chk("miss", miss_pulse, m_miss);
      chk("score", score, m_score);
      chk("wr_en", wr_en, m_dirty & ~cpu_rwe);
      chk("wr_data", wr_data, m_score);
      chk("wr_reg", wr_reg, 30);
    end
  end

  task automatic do_reset();
    btn_n = 1'b1;
    cpu_rwe = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      bp[i] = 1'b1;
      rp[i] = 1'b0;
    end
  endtask

  task automatic set_bp(input int a, input int b, input logic v);
    for (int i = a; i <= b; i++) bp[i] = v;
  endtask

  task automatic set_rp(input int a, input int b, input logic v);
    for (int i = a; i <= b; i++) rp[i] = v;
  endtask

  // entry i holds the inputs sampled at edge i, the write taken at edge i and the outputs after it
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      btn_n = bp[i];
      cpu_rwe = rp[i];
      #1;
      w[i] = wr_en;
      d[i] = wr_data;
      @(posedge clk);
      #1;
      h[i] = hit_pulse;
      m[i] = miss_pulse;
      l[i] = mole_led;
      s[i] = score;
    end
  endtask

  task automatic tally(input int a, input int b);
    nh = 0; nm = 0; nw = 0; fh = 0; fm = 0; nl = 0;
    for (int i = a; i <= b; i++) begin
      if (h[i]) begin nh++; if (fh == 0) fh = i; end
      if (m[i]) begin nm++; if (fm == 0) fm = i; end
      if (w[i]) nw++;
      if (!l[i]) nl++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("t1_led", mole_led, 1);
    chk("t1_score", score, 0);
    chk("t1_wr_en", wr_en, 0);
    chk("t1_hit", hit_pulse, 0);
    chk("t1_miss", miss_pulse, 0);
    chk("t1_wr_reg", wr_reg, 30);

    do_reset();
    set_bp(1, 10, 1'b0);
    run(15);
    tally(1, 15);
    chk("t2_hit_cycle", fh, 7);
    chk("t2_hits", nh, 1);
    chk("t2_led_after", l[8], 0);
    chk("t2_score", s[10], 1);
    chk("t2_wr_count", nw, 1);
    chk("t2_wr_cycle", w[8], 1);
    chk("t2_wr_data", d[8], 1);

    do_reset();
    for (int i = 1; i <= 16; i++) bp[i] = ((i - 1) / 2) % 2 == 0;
    run(19);
    tally(1, 19);
    chk("t3_hits", nh, 0);
    chk("t3_score", s[19], 0);
    chk("t3_led", l[19], 1);

    do_reset();
    set_bp(21, 25, 1'b0);
    run(40);
    tally(1, 40);
    chk("t4_miss_cycle", fm, 20);
    chk("t4_misses", nm, 1);
    chk("t4_dark_cycles", nl, 10);
    chk("t4_led_before", l[19], 1);
    chk("t4_relit", l[30], 1);
    chk("t4_dark_press_hits", nh, 0);
    chk("t4_score", s[40], 0);

    do_reset();
    set_rp(1, 30, 1'b1);
    set_bp(1, 5, 1'b0);
    set_bp(18, 22, 1'b0);
    run(40);
    tally(1, 30);
    chk("t5_hits", nh, 2);
    chk("t5_blocked_wr", nw, 0);
    chk("t5_relit", l[17], 1);
    chk("t5_score", s[30], 2);
    tally(31, 40);
    chk("t5_wr_count", nw, 1);
    chk("t5_wr_cycle", w[31], 1);
    chk("t5_wr_data", d[31], 2);

    do_reset();
    set_rp(1, 10, 1'b1);
    set_bp(1, 5, 1'b0);
    run(10);
    cpu_rwe = 1'b0;
    #1;
    chk("t6_pre_wr_en", wr_en, 1);
    chk("t6_pre_led", mole_led, 0);
    chk("t6_pre_score", score, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_led", mole_led, 1);
    chk("t6_score", score, 0);
    chk("t6_wr_en", wr_en, 0);
    chk("t6_hit", hit_pulse, 0);
    do_reset();
    run(5);
    chk("t6_after_score", s[5], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
